fifo_read_drain: RTL and testbench

//  Read-side engine for asynchronous_fifo, in the rclk domain. On start it pulls

---
 rtl/fifo_read_drain.sv | 166 ++++++++++++++++
 tb/tb_fifo_read_drain.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_drain.sv
`default_nettype none
// ============================================================================
// Module  : fifo_read_drain
// Brief   : Read-side burst engine: pulls words from a FIFO read port and
//           streams them out through a small skid buffer.
// Revision: 1.0
// ============================================================================
module fifo_read_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W:0] c_depth = (OCC_W + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_WIDTH-1:0]  r_len;
    logic [CNT_WIDTH-1:0]  r_issued;
    logic [CNT_WIDTH-1:0]  r_rd_count;
    logic                  r_inflight;
    logic                  r_zero_done;
    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [OCC_W-1:0]      r_occ;

    logic                  w_start_ok;
    logic                  w_start_zero;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_credit_ok;
    logic                  w_drained;
    logic                  w_drain_done;
    logic [CNT_WIDTH-1:0]  w_issued_inc;

    assign w_start_ok   = (r_state == S_IDLE) && start && (burst_len != '0);
    assign w_start_zero = (r_state == S_IDLE) && start && (burst_len == '0);
    assign w_push       = r_inflight;
    assign w_pop        = m_valid && m_ready;
    assign w_issued_inc = r_issued + CNT_WIDTH'(1);
    assign w_drained    = !r_inflight && (r_occ == '0);

    // Credit counts registered occupancy plus the word in flight; a pop in
    // the same cycle is deliberately not credited to keep the path short.
    assign w_credit_ok = (({1'b0, r_occ}) + (OCC_W + 1)'(r_inflight)) < c_depth;

    assign fifo_r_en = (r_state == S_RUN) && !fifo_empty &&
                       (r_issued < r_len) && w_credit_ok;

    assign m_valid  = (r_occ != '0);
    assign m_data   = r_mem[r_rd_ptr];
    assign rd_count = r_rd_count;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_drain_done = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (fifo_r_en && (w_issued_inc == r_len)) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_drained) begin
                    w_next_state = S_IDLE;
                    w_drain_done = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        done = w_drain_done || r_zero_done;
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_len       <= '0;
            r_issued    <= '0;
            r_rd_count  <= '0;
            r_inflight  <= 1'b0;
            r_zero_done <= 1'b0;
        end else begin
            r_inflight  <= fifo_r_en;
            r_zero_done <= w_start_zero;
            if (w_start_ok) begin
                r_len      <= burst_len;
                r_issued   <= '0;
                r_rd_count <= '0;
            end else begin
                if (fifo_r_en) begin
                    r_issued <= w_issued_inc;
                end
                if (w_pop) begin
                    r_rd_count <= r_rd_count + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Skid buffer: pointers wrap naturally at BUF_DEPTH.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= fifo_data_out;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_drain.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_read_drain
// Brief   : Scoreboard bench for fifo_read_drain with a FIFO read-port model.
// Revision: 1.0
// ============================================================================
module tb_fifo_read_drain;

    localparam int DW = 8;
    localparam int BD = 4;
    localparam int CW = 16;
    localparam int FSZ = 4096;

    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] burst_len = '0;
    logic          busy, done, fifo_empty, fifo_r_en, m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] fifo_data_out = '0;
    logic [DW-1:0] m_data;
    logic [CW-1:0] rd_count;

    always #5 rclk = ~rclk;

    fifo_read_drain #(.DATA_WIDTH(DW), .BUF_DEPTH(BD), .CNT_WIDTH(CW)) dut (
        .rclk(rclk), .rrst(rrst), .start(start), .burst_len(burst_len),
        .busy(busy), .done(done), .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en),
        .fifo_data_out(fifo_data_out), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .rd_count(rd_count)
    );

    // FIFO model: contents are pre-generated; writes only advance wr_idx.
    logic [DW-1:0] fmem [FSZ];
    int wr_idx = 0;
    int rd_idx = 0;
    assign fifo_empty = (rd_idx == wr_idx);

    always @(posedge rclk) begin
        if (fifo_r_en) begin
            fifo_data_out <= fmem[rd_idx];
            rd_idx        <= rd_idx + 1;
        end
    end

    int cycle = 0;
    always @(posedge rclk) cycle <= cycle + 1;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    int  cur_len = 0, iss = 0, n_popped = 0, ren_cnt = 0, done_cnt = 0;
    int  first_ren_cyc = -1, last_pop_cyc = 0;
    bit  burst_active = 0;
    bit  hold_valid = 0;
    logic [DW-1:0] held_data = '0;
    int  ready_mode = 0;
    int  wr_every = 0;
    int  wr_phase = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares every delivered word and the read-enable rule.
    always @(negedge rclk) begin
        bit exp_ren;
        if (rrst) begin
            hold_valid = 0;
        end else begin
            chk("rd_count", 32'(rd_count), n_popped);
            chk("busy", 32'(busy), 32'(burst_active));
            exp_ren = burst_active && !fifo_empty && (iss < cur_len) && ((iss - n_popped) < BD);
            chk("fifo_r_en", 32'(fifo_r_en), 32'(exp_ren));
            if (hold_valid) begin
                chk("m_valid_hold", 32'(m_valid), 32'd1);
                chk("m_data_hold", 32'(m_data), 32'(held_data));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word actual=%0h required=none", m_data);
                end else begin
                    chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
                    n_popped++;
                    last_pop_cyc = cycle;
                end
            end
            hold_valid = m_valid && !m_ready;
            held_data  = m_data;
            if (fifo_r_en) begin
                iss++;
                ren_cnt++;
                if (first_ren_cyc < 0) first_ren_cyc = cycle;
            end
            if (done) begin
                done_cnt++;
                chk("done_drained", exp_q.size(), 32'd0);
                burst_active = 0;
            end
        end
    end

    // Ready pattern and background FIFO writer.
    always @(posedge rclk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'b0;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        if (wr_every > 0) begin
            wr_phase++;
            if (wr_phase >= wr_every && wr_idx < FSZ - 64) begin
                wr_phase = 0;
                wr_idx++;
            end
        end
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic fifo_write(input int n);
        wr_idx += n;
    endtask

    task automatic do_start(input int len);
        first_ren_cyc = -1;
        ren_cnt       = 0;
        start         = 1'b1;
        burst_len     = CW'(len);
        tick();
        start = 1'b0;
        if (len != 0) begin
            iss      = 0;
            n_popped = 0;
            cur_len  = len;
            for (int k = 0; k < len; k++) exp_q.push_back(fmem[rd_idx + k]);
            burst_active = 1;
        end
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done within %0d cycles", budget);
            burst_active = 0;
            exp_q.delete();
        end
    endtask

    initial begin
        int d0;
        int waited;
        for (int i = 0; i < FSZ; i++) fmem[i] = DW'($urandom);

        // Reset values
        repeat (3) @(posedge rclk);
        @(negedge rclk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_r_en", 32'(fifo_r_en), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_rd_count", 32'(rd_count), 0);
        tick();
        rrst = 1'b0;
        tick();

        // Basic 5-word burst
        ready_mode = 0;
        fifo_write(5);
        d0 = done_cnt;
        do_start(5);
        wait_done(60);
        repeat (3) tick();
        chk("t1_ren_cnt", ren_cnt, 5);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_rd_count", 32'(rd_count), 5);
        chk("t1_busy", 32'(busy), 0);

        // Backpressure: issue stops at the buffer depth
        ready_mode = 1;
        fifo_write(16);
        do_start(16);
        repeat (10) tick();
        chk("t2_ren_stall", ren_cnt, BD);
        ready_mode = 0;
        wait_done(200);
        chk("t2_popped", n_popped, 16);
        chk("t2_ren_cnt", ren_cnt, 16);

        // Slow producer into an empty FIFO
        chk("t3_empty", 32'(fifo_empty), 1);
        do_start(4);
        wr_every = 3;
        wait_done(200);
        wr_every = 0;
        chk("t3_popped", n_popped, 4);
        chk("t3_ren_cnt", ren_cnt, 4);

        // Zero-length burst
        do_start(0);
        @(negedge rclk);
        chk("t4_done", 32'(done), 1);
        chk("t4_busy", 32'(busy), 0);
        @(negedge rclk);
        chk("t4_done_drop", 32'(done), 0);
        chk("t4_ren_cnt", ren_cnt, 0);
        tick();

        // Reset in the middle of a burst
        fifo_write(8);
        do_start(8);
        waited = 0;
        while (n_popped < 3 && waited < 100) begin
            @(negedge rclk);
            waited++;
        end
        chk("t5_reached3", 32'(n_popped >= 3), 1);
        #1;
        rrst = 1'b1;
        burst_active = 0;
        exp_q.delete();
        #1;
        chk("t5_r_en", 32'(fifo_r_en), 0);
        chk("t5_m_valid", 32'(m_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_rd_count", 32'(rd_count), 0);
        tick();
        tick();
        rrst = 1'b0;
        iss = 0;
        n_popped = 0;
        cur_len = 0;
        tick();
        fifo_write(2);
        do_start(2);
        wait_done(60);
        chk("t5_popped", n_popped, 2);

        // Full-rate burst; starts during RUN must be ignored
        fifo_write(40);
        ready_mode = 0;
        do_start(20);
        for (int k = 0; k < 3; k++) begin
            tick();
            start = 1'b1;
            burst_len = CW'($urandom_range(1, 9));
            tick();
            start = 1'b0;
        end
        wait_done(200);
        chk("t6_popped", n_popped, 20);
        chk("t6_cycles", last_pop_cyc - first_ren_cyc, 21);
        repeat (3) tick();
        chk("t6_idle", 32'(busy), 0);

        // Randomized bursts
        for (int b = 0; b < 8; b++) begin
            int len = $urandom_range(1, 24);
            ready_mode = 2;
            fifo_write($urandom_range(0, len));
            wr_every = $urandom_range(1, 3);
            do_start(len);
            wait_done(2000);
            chk("rand_popped", n_popped, len);
            chk("rand_ren_cnt", ren_cnt, len);
            wr_every = 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
